// File: rtl/gray_code_counter_updown_if.sv
// Bus between the up/down Gray counter and its user: controls in, count and strobes out.
// GRAY_CNT_LOAD_EN adds the synchronous load strobe and its Gray-coded value.
interface gray_code_counter_updown_if #(
    parameter int BITS = 8
);
    logic            en;
    logic            dir;
`ifdef GRAY_CNT_LOAD_EN
    logic            load;
    logic [BITS-1:0] load_value;
`endif
    logic [BITS-1:0] value;
    logic [BITS-1:0] binary;
    logic            step;
    logic            wrap;

`ifdef GRAY_CNT_LOAD_EN
    modport master (
        output en, dir, load, load_value,
        input  value, binary, step, wrap
    );

    modport slave (
        input  en, dir, load, load_value,
        output value, binary, step, wrap
    );
`else
    modport master (
        output en, dir,
        input  value, binary, step, wrap
    );

    modport slave (
        input  en, dir,
        output value, binary, step, wrap
    );
`endif
endinterface

// File: rtl/gray_code_counter_updown.sv
// Prescaled up/down Gray counter with registered binary shadow and step/wrap strobes.
// Optional synchronous load is built only when GRAY_CNT_LOAD_EN is defined.
module gray_code_counter_updown #(
    parameter int CLOCK_MHZ = 16,
    parameter int PRESCALE  = 16,
    parameter int BITS      = 8
) (
    input logic                        clk,
    input logic                        rst,
    gray_code_counter_updown_if.slave  bus
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   PMAX = PW'(PRESCALE - 1);
    localparam logic [BITS-1:0] ONE  = BITS'(1);

    if (PRESCALE < 1 || BITS < 2 || CLOCK_MHZ < 1) begin : g_bad_param
        $error("gray_code_counter_updown: illegal parameter set");
    end

    function automatic logic [BITS-1:0] bin2gray(input logic [BITS-1:0] b);
        return b ^ (b >> 1);
    endfunction

`ifdef GRAY_CNT_LOAD_EN
    // Prefix XOR from the MSB down recovers the binary weight of each bit.
    function automatic logic [BITS-1:0] gray2bin(input logic [BITS-1:0] g);
        logic [BITS-1:0] b;
        b[BITS-1] = g[BITS-1];
        for (int i = BITS - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction
`endif

    logic [PW-1:0]   pcnt_q, pcnt_d;
    logic [BITS-1:0] bin_q,  bin_d;
    logic [BITS-1:0] gray_q, gray_d;
    logic            step_q, step_d;
    logic            wrap_q, wrap_d;
    logic            tick;

    assign tick = bus.en && (pcnt_q == PMAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_q <= '0;
            bin_q  <= '0;
            gray_q <= '0;
            step_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            pcnt_q <= pcnt_d;
            bin_q  <= bin_d;
            gray_q <= gray_d;
            step_q <= step_d;
            wrap_q <= wrap_d;
        end
    end

    // Load outranks a coincident tick; that tick is simply dropped.
    always_comb begin
        pcnt_d = pcnt_q;
        bin_d  = bin_q;
        gray_d = gray_q;
        step_d = 1'b0;
        wrap_d = 1'b0;
`ifdef GRAY_CNT_LOAD_EN
        if (bus.load) begin
            pcnt_d = '0;
            gray_d = bus.load_value;
            bin_d  = gray2bin(bus.load_value);
        end else
`endif
        if (tick) begin
            pcnt_d = '0;
            bin_d  = bus.dir ? (bin_q + ONE) : (bin_q - ONE);
            gray_d = bin2gray(bin_d);
            step_d = 1'b1;
            wrap_d = bus.dir ? (bin_q == '1) : (bin_q == '0);
        end else if (bus.en) begin
            pcnt_d = pcnt_q + PW'(1);
        end
    end

    assign bus.value  = gray_q;
    assign bus.binary = bin_q;
    assign bus.step   = step_q;
    assign bus.wrap   = wrap_q;

endmodule

// File: doc/gray_code_counter_updown.md
# gray_code_counter_updown

Parametrised up/down Gray-code counter with an integrated prescaler. It is the next generation of the free-running 1 MHz Gray counter and adds an asynchronous reset, a count enable, direction control, a registered binary shadow, step and wrap strobes, and an optional synchronous load. It sits between a system clock domain and any consumer that samples the count asynchronously, such as encoders, FIFO pointers or off-chip displays. `value` therefore changes at most one bit per step and is driven straight from flops.

## Interface

Parameters:
- `CLOCK_MHZ`, 16: informational only; documents the system clock frequency.
- `PRESCALE`, 16: enabled `clk` cycles per count step. Must be ≥ 1; 1 means a step on every enabled cycle.
- `BITS`, 8: counter width. Must be ≥ 2.

Ports:
- `clk`, input, 1: system clock; all logic rising-edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `en`, input, 1: count enable; gates the prescaler.
- `dir`, input, 1: 1 counts up, 0 counts down; sampled on the tick cycle.
- `load`, input, 1: synchronous load strobe. Present only with `GRAY_CNT_LOAD_EN`.
- `load_value`, input, `BITS`: Gray-coded load value. Present only with `GRAY_CNT_LOAD_EN`.
- `value`, output, `BITS`: registered Gray count.
- `binary`, output, `BITS`: registered binary equivalent of `value`.
- `step`, output, 1: one-cycle pulse, high in the first cycle `value` holds a stepped count.
- `wrap`, output, 1: one-cycle pulse coincident with `step` when the count rolled over.

## Operation

- Prescaler `pcnt`, width `$clog2(PRESCALE)` (minimum 1):
  - Increments on each edge with `en`=1.
  - Holds its value when `en`=0; it is not cleared.
  - Internal `tick` = `en` && (`pcnt`==`PRESCALE`-1). On a tick, `pcnt` returns to 0.
- On a tick edge:
  - `binary` ← `binary`+1 if `dir`=1, else `binary`−1, modulo 2^`BITS`.
  - `value` ← next_bin ^ (next_bin>>1).
  - `step` ← 1.
  - `wrap` ← 1 if (`dir`=1 and `binary`==all-ones) or (`dir`=0 and `binary`==0).
- On a non-tick edge: `step` ← 0, `wrap` ← 0, count holds.
- Load (macro defined), `load`=1 at an edge:
  - `value` ← `load_value`.
  - `binary` ← Gray-to-binary of `load_value` (prefix XOR from MSB).
  - `pcnt` ← 0.
  - `step` ← 0, `wrap` ← 0.
  - Load has priority over a coincident tick; that tick is discarded.
  - Load is honoured regardless of `en`.
- `value` and `binary` always correspond, i.e. `value` == `binary`^(`binary`>>1), in every cycle.
- Direction changes between ticks are legal. Only `dir` at the tick edge matters, and a reversal still changes exactly one bit of `value`.

## Timing

- Reset (`rst`=1, asynchronous, no clock needed): `value`=0, `binary`=0, `pcnt`=0, `step`=0, `wrap`=0. Outputs hold while `rst` is high.
- Reset mid-count discards the count and the prescaler phase.
- After `rst` deasserts with `en`=1 continuously, the first step is visible after the `PRESCALE`th rising edge. Subsequent steps occur every `PRESCALE` edges.
- Latency from the tick edge to `value`/`binary`/`step`/`wrap` update is 0 cycles: the outputs are registered at that edge.
- Load latency is 1 edge: the new value is visible after the edge that sampled `load`=1.
- After a load with `en` high, the next step occurs `PRESCALE` edges later.
- `en` deasserted for N cycles delays the next step by exactly N cycles.

## Configuration

- `GRAY_CNT_LOAD_EN` defined:
  - `load` and `load_value` ports exist, along with the Gray-to-binary converter and load priority logic.
- `GRAY_CNT_LOAD_EN` undefined:
  - Neither port exists and no load logic is synthesised.
  - The counter is reachable only through reset and stepping.
  - All other behaviour is identical.

## Test plan

All scenarios use `BITS`=4, `PRESCALE`=4.

- Reset: hold `rst`=1, then release with `en`=1, `dir`=1. Required: `value`=0000, `step`=0 while in reset; `value`=0001, `binary`=0001, `step`=1 for exactly one cycle after the 4th edge.
- Full up cycle: count 16 steps. Required: `value` runs 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0 (hex), with exactly one bit changing per step and `wrap`=1 only on the 8→0 step.
- Down wrap: from reset, `dir`=0. Required: first step gives `value`=1000, `binary`=1111, `wrap`=1; next step gives `value`=1001, `binary`=1110.
- Enable hold: `en`=1 for 2 edges, 0 for 10 edges, then 1. Required: the step occurs after 2 further enabled edges, i.e. 14 edges after release.
- Load (macro defined): `load`=1 with `load_value`=1100 on a tick edge. Required: `value`=1100, `binary`=1000, `step`=0. The next up-step comes 4 edges later with `value`=1101.
- Async reset: assert `rst` between clock edges while `value`=0111. Required: all outputs go to 0 immediately, before the next edge.
